// File: rtl/dense_layer_fx.sv
// dense_layer_fx
// Fixed-point fully-connected layer: out[j] = act(sum_k in[k]*W[j][k] + b[j]).
// LANES neurons are accumulated in parallel, one input element per cycle, so a
// full vector takes (N_NEURONS/LANES)*(N_INPUTS+2) cycles after start.
//
// Build option:
//   DENSE_SAT_EN  defined   -> output reduction saturates to the DATA_W range
//                 undefined -> output reduction keeps the low DATA_W bits (wraps)
//   The accumulator itself never saturates in either build.
//
// Ports:
//   CLK, reset            clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data parameter RAM write port (IDLE only). Weight W[j][k]
//                         lives at j*N_INPUTS+k, bias b[j] at N_NEURONS*N_INPUTS+j
//   act_mode              0 = identity, 1 = ReLU; sampled when start is accepted
//   start, in_vec         request and input vector (element k at [k*DATA_W +: DATA_W])
//   busy                  high whenever the FSM is not IDLE
//   out_valid/out_ready   result handshake
//   out_vec               neuron j at [j*DATA_W +: DATA_W]; held until overwritten
//   state_dbg             current FSM state (0 IDLE, 1 MAC, 2 BIAS, 3 ACT, 4 DONE)
//
// Handshake: start is accepted on any clock edge where the FSM is IDLE and
// start=1. A result is transferred on any edge where out_valid=1 and
// out_ready=1; out_valid drops the following cycle. start seen outside IDLE
// is dropped, never queued.
module dense_layer_fx #(
  parameter int N_INPUTS  = 16,
  parameter int N_NEURONS = 8,
  parameter int LANES     = 1,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int ACC_W     = 40
) (
  input  logic                                      CLK,
  input  logic                                      reset,
  input  logic                                      wr_en,
  input  logic [$clog2(N_NEURONS*(N_INPUTS+1))-1:0] wr_addr,
  input  logic [DATA_W-1:0]                         wr_data,
  input  logic                                      act_mode,
  input  logic                                      start,
  input  logic [N_INPUTS*DATA_W-1:0]                in_vec,
  output logic                                      busy,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [N_NEURONS*DATA_W-1:0]               out_vec,
  output logic [2:0]                                state_dbg
);

  localparam int DEPTH     = N_NEURONS*(N_INPUTS+1);
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int G         = N_NEURONS/LANES;
  localparam int KW        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int GW        = (G > 1) ? $clog2(G) : 1;
  localparam int BIAS_BASE = N_NEURONS*N_INPUTS;

  localparam logic [KW-1:0]   K_LAST  = KW'(N_INPUTS-1);
  localparam logic [GW-1:0]   G_LAST  = GW'(G-1);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

`ifdef DENSE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_BIAS = 3'd2,
    S_ACT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_n;

  logic [KW-1:0]            k_q;
  logic [GW-1:0]            g_q;
  logic                     act_q;
  logic [DATA_W-1:0]        in_mem [N_INPUTS];
  logic [DATA_W-1:0]        ram    [DEPTH];
  logic signed [ACC_W-1:0]  acc_q  [LANES];
  logic [N_NEURONS*DATA_W-1:0] out_vec_q;

  // Per-lane combinational datapath
  logic [ADDR_W-1:0]          w_addr    [LANES];
  logic [ADDR_W-1:0]          b_addr    [LANES];
  logic signed [2*DATA_W-1:0] prod      [LANES];
  logic signed [ACC_W-1:0]    mac_term  [LANES];
  logic signed [ACC_W-1:0]    bias_term [LANES];
  logic                       relu_zero [LANES];
  logic [DATA_W-1:0]          act_res   [LANES];
`ifdef DENSE_SAT_EN
  logic signed [ACC_W-1:0]    shifted   [LANES];
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (start) state_n = S_MAC;
      S_MAC:  if (k_q == K_LAST) state_n = S_BIAS;
      S_BIAS: state_n = S_ACT;
      S_ACT:  state_n = (g_q == G_LAST) ? S_DONE : S_MAC;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    state_dbg = state_q;
  end

  assign out_vec = out_vec_q;

  // Parameter RAM: not reset, writable only while IDLE and in range. A write
  // coinciding with start acceptance lands before the first MAC read.
  always_ff @(posedge CLK) begin
    if (wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < DEPTH_V))
      ram[wr_addr] <= wr_data;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_addr[l]    = ADDR_W'((int'(g_q)*LANES + l)*N_INPUTS + int'(k_q));
      b_addr[l]    = ADDR_W'(BIAS_BASE + int'(g_q)*LANES + l);
      prod[l]      = $signed(in_mem[k_q]) * $signed(ram[w_addr[l]]);
      mac_term[l]  = ACC_W'(prod[l]);
      // Bias is a Q.FRAC_W value; align it with the Q.2*FRAC_W products.
      bias_term[l] = ACC_W'($signed(ram[b_addr[l]])) <<< FRAC_W;
      // Sign of acc equals sign of acc>>>FRAC_W, so ReLU can look at acc.
      relu_zero[l] = act_q && acc_q[l][ACC_W-1];
`ifdef DENSE_SAT_EN
      shifted[l] = acc_q[l] >>> FRAC_W;
      if (relu_zero[l])              act_res[l] = '0;
      else if (shifted[l] > SAT_MAX) act_res[l] = SAT_MAX[DATA_W-1:0];
      else if (shifted[l] < SAT_MIN) act_res[l] = SAT_MIN[DATA_W-1:0];
      else                           act_res[l] = shifted[l][DATA_W-1:0];
`else
      act_res[l] = relu_zero[l] ? '0 : DATA_W'(acc_q[l] >>> FRAC_W);
`endif
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      k_q       <= '0;
      g_q       <= '0;
      act_q     <= 1'b0;
      out_vec_q <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      for (int i = 0; i < N_INPUTS; i++) in_mem[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_INPUTS; i++)
              in_mem[i] <= in_vec[i*DATA_W +: DATA_W];
            act_q <= act_mode;
            g_q   <= '0;
            k_q   <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
          end
        end
        S_MAC: begin
          for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + mac_term[l];
          k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
        S_BIAS: begin
          for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + bias_term[l];
        end
        S_ACT: begin
          for (int l = 0; l < LANES; l++)
            out_vec_q[(int'(g_q)*LANES + l)*DATA_W +: DATA_W] <= act_res[l];
          if (g_q != G_LAST) begin
            g_q <= g_q + 1'b1;
            k_q <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_fx.sv
// Bench for dense_layer_fx: two instances (LANES=1 and LANES=2) share all
// inputs so latency and values of both lane configurations are checked on the
// same stimulus. N_INPUTS=4, N_NEURONS=2, DATA_W=16, FRAC_W=8.
module tb_dense_layer_fx;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int AW = 40;
  localparam int VW = NN*DW;
`ifdef DENSE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          CLK;
  logic          reset;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          act_mode;
  logic          start;
  logic [NI*DW-1:0] in_vec;
  logic          out_ready;

  logic          busy1, valid1, busy2, valid2;
  logic [VW-1:0] vec1, vec2;
  logic [2:0]    dbg1, dbg2;

  dense_layer_fx #(.N_INPUTS(NI), .N_NEURONS(NN), .LANES(1), .DATA_W(DW),
                   .FRAC_W(FW), .ACC_W(AW)) u_dut1 (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .act_mode(act_mode), .start(start), .in_vec(in_vec),
    .busy(busy1), .out_valid(valid1), .out_ready(out_ready), .out_vec(vec1),
    .state_dbg(dbg1)
  );

  dense_layer_fx #(.N_INPUTS(NI), .N_NEURONS(NN), .LANES(2), .DATA_W(DW),
                   .FRAC_W(FW), .ACC_W(AW)) u_dut2 (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .act_mode(act_mode), .start(start), .in_vec(in_vec),
    .busy(busy2), .out_valid(valid2), .out_ready(out_ready), .out_vec(vec2),
    .state_dbg(dbg2)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string            name;
    logic [NI*DW-1:0] x;
    logic [NN*NI*DW-1:0] w;
    logic [NN*DW-1:0] b;
    logic             act;
    logic [VW-1:0]    exp;
  } vec_t;

  vec_t          vecs[$];
  logic [VW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [NI*DW-1:0] rep(input logic [DW-1:0] v);
    return {NI{v}};
  endfunction

  // Reference: integer arithmetic on 64-bit values, floor shift, then the
  // build-selected reduction to 16 bits.
  function automatic logic [VW-1:0] model(input logic [NI*DW-1:0] x,
                                          input logic [NN*NI*DW-1:0] w,
                                          input logic [NN*DW-1:0] b,
                                          input logic act);
    logic [VW-1:0] r;
    r = '0;
    for (int j = 0; j < NN; j++) begin
      longint s;
      logic signed [DW-1:0] xs, ws, bs;
      s = 0;
      for (int k = 0; k < NI; k++) begin
        xs = x[k*DW +: DW];
        ws = w[(j*NI+k)*DW +: DW];
        s += longint'(xs) * longint'(ws);
      end
      bs = b[j*DW +: DW];
      s += longint'(bs) * 256;
      s = s >>> FW;
      if (act && s < 0) s = 0;
      if (SAT) begin
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
      end
      r[j*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  function automatic vec_t mk(input string name, input logic [NI*DW-1:0] x,
                              input logic [NN*NI*DW-1:0] w, input logic [NN*DW-1:0] b,
                              input logic act, input logic [VW-1:0] exp);
    vec_t v;
    v.name = name; v.x = x; v.w = w; v.b = b; v.act = act; v.exp = exp;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_param(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int a = 0; a < NN*NI; a++) write_param(a, v.w[a*DW +: DW]);
    for (int j = 0; j < NN; j++) write_param(NN*NI + j, v.b[j*DW +: DW]);
    write_param(13, 16'h7FFF);  // beyond the parameter space
    write_param(15, 16'h8000);
  endtask

  task automatic start_txn(input vec_t v);
    in_vec   = v.x;
    act_mode = v.act;
    start    = 1'b1;
    exp_q.push_back(v.exp);
    tick();
    start    = 1'b0;
  endtask

  // Waits (bounded) until both instances present a result; latencies are
  // counted from the start-acceptance edge.
  task automatic wait_done(input int base, output int l1, output int l2);
    l1 = -1;
    l2 = -1;
    for (int c = base + 1; c <= base + 100; c++) begin
      tick();
      if (valid1 && l1 < 0) l1 = c;
      if (valid2 && l2 < 0) l2 = c;
      if (valid1 && valid2) break;
    end
  endtask

  task automatic collect(input string name);
    logic [VW-1:0] e;
    check({name, " queue"}, 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({name, " out_vec lanes1"}, 64'(vec1), 64'(e));
    check({name, " out_vec lanes2"}, 64'(vec2), 64'(e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid1 after accept"}, 64'(valid1), 64'd0);
    check({name, " valid2 after accept"}, 64'(valid2), 64'd0);
    check({name, " busy1 after accept"},  64'(busy1),  64'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int l1, l2;
    start_txn(v);
    wait_done(0, l1, l2);
    check({v.name, " latency lanes1"}, 64'(l1), 64'd12);
    check({v.name, " latency lanes2"}, 64'(l2), 64'd6);
    collect(v.name);
  endtask

  // ---------------- test ----------------
  initial begin
    int l1, l2;
    vec_t v;
    logic [NI*DW-1:0] rx;
    logic [NN*NI*DW-1:0] rw;
    logic [NN*DW-1:0] rb;
    logic ra;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; act_mode = 1'b0;
    start = 1'b0; in_vec = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("reset busy1",  64'(busy1),  64'd0);
    check("reset valid1", 64'(valid1), 64'd0);
    check("reset vec1",   64'(vec1),   64'd0);
    check("reset vec2",   64'(vec2),   64'd0);
    check("reset state",  64'(dbg1),   64'd0);
    reset = 1'b0;
    tick();

    vecs.push_back(mk("case1_identity", rep(16'h0100), {rep(16'hFF00), rep(16'h0100)},
                      {16'h0000, 16'h0080}, 1'b0, 32'hFC00_0480));
    vecs.push_back(mk("case2_relu", rep(16'h0100), {rep(16'hFF00), rep(16'h0100)},
                      {16'h0000, 16'h0080}, 1'b1, 32'h0000_0480));
    vecs.push_back(mk("overflow", rep(16'h4000), {rep(16'hFE00), rep(16'h0200)},
                      32'h0, 1'b0, SAT ? 32'h8000_7FFF : 32'h0000_0000));
    vecs.push_back(mk("overflow_relu", rep(16'h4000), {rep(16'hFE00), rep(16'h0200)},
                      32'h0, 1'b1, SAT ? 32'h0000_7FFF : 32'h0000_0000));
    vecs.push_back(mk("floor_shift", rep(16'h0001), {rep(16'hFFFF), rep(16'h0001)},
                      32'h0, 1'b0, 32'hFFFF_0000));
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NI; k++) rx[k*DW +: DW] = 16'($urandom_range(0, 65535));
      for (int a = 0; a < NN*NI; a++) rw[a*DW +: DW] = 16'($urandom_range(0, 65535));
      for (int j = 0; j < NN; j++) rb[j*DW +: DW] = 16'($urandom_range(0, 65535));
      ra = 1'($urandom_range(0, 1));
      vecs.push_back(mk($sformatf("random%0d", r), rx, rw, rb, ra, model(rx, rw, rb, ra)));
    end

    foreach (vecs[i]) begin
      load(vecs[i]);
      run_txn(vecs[i]);
    end

    // Backpressure, stray start/write while busy, start while DONE.
    v = vecs[0];
    load(v);
    start_txn(v);
    in_vec  = rep(16'h7777);
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 16'h7FFF;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("bp busy during MAC", 64'(busy1), 64'd1);
    wait_done(1, l1, l2);
    check("bp latency lanes1", 64'(l1), 64'd12);
    for (int c = 0; c < 5; c++) begin
      start = (c < 2);
      tick();
      check($sformatf("bp hold valid c%0d", c), 64'(valid1), 64'd1);
      check($sformatf("bp hold vec c%0d", c), 64'(vec1), 64'(v.exp));
    end
    start = 1'b0;
    collect("backpressure");
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("no second result busy c%0d", c), 64'(busy1), 64'd0);
      check($sformatf("no second result valid c%0d", c), 64'(valid2), 64'd0);
    end
    check("out_vec held in IDLE", 64'(vec1), 64'(v.exp));

    // Reset during MAC, then restart without reloading the RAM.
    in_vec = v.x; act_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort state is MAC", 64'(dbg1), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy1",  64'(busy1),  64'd0);
    check("abort busy2",  64'(busy2),  64'd0);
    check("abort valid1", 64'(valid1), 64'd0);
    check("abort vec1",   64'(vec1),   64'd0);
    check("abort vec2",   64'(vec2),   64'd0);
    v.name = "restart_no_reload";
    run_txn(v);

    // Bias write in the same cycle as start acceptance is used by that run.
    in_vec = v.x; act_mode = 1'b0; start = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h0180;
    exp_q.push_back(32'hFC00_0580);
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done(0, l1, l2);
    check("write_at_start latency lanes1", 64'(l1), 64'd12);
    collect("write_at_start");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dense_layer_fx.md
Name: dense_layer_fx

Overview:
- Parametrised fixed-point fully-connected layer: out[j] = act(sum_k in[k]*W[j][k] + b[j]) for N_NEURONS neurons over N_INPUTS inputs.
- Time-multiplexed MAC: LANES neurons computed in parallel, one input element per cycle.
- Weights and biases live in an internal RAM loaded through a write port. Start/done uses a valid/ready handshake.
- Chains layer-to-layer inside the MLP top: out_valid/out_vec of one layer feed start/in_vec of the next.

Parameters:
- N_INPUTS, 16: input vector length.
- N_NEURONS, 8: neuron/output count; must be a multiple of LANES.
- LANES, 1: parallel MAC lanes.
- DATA_W, 16: signed two's-complement width of inputs, weights, biases and outputs.
- FRAC_W, 8: fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
- ACC_W, 40: signed accumulator width; must be >= 2*DATA_W + clog2(N_INPUTS) + 1.

Ports:
- CLK, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- wr_en, in, 1: parameter RAM write strobe.
- wr_addr, in, clog2(N_NEURONS*(N_INPUTS+1)): weight addr j*N_INPUTS+k; bias addr N_NEURONS*N_INPUTS+j.
- wr_data, in, DATA_W: weight/bias value.
- act_mode, in, 1: 0 = identity, 1 = ReLU; sampled at start acceptance.
- start, in, 1: request; accepted only in IDLE.
- in_vec, in, N_INPUTS*DATA_W: input k at bits [k*DATA_W +: DATA_W]; captured at start acceptance.
- busy, out, 1: high in any state other than IDLE.
- out_valid, out, 1: result vector available.
- out_ready, in, 1: consumer accepts result.
- out_vec, out, N_NEURONS*DATA_W: neuron j at bits [j*DATA_W +: DATA_W].

Behaviour:
- Reset:
  - state = IDLE; busy = 0; out_valid = 0; out_vec = 0; accumulators, counters and captured inputs cleared.
  - Parameter RAM is NOT cleared.
  - Reset in any state, including mid-MAC, aborts the computation within the same cycle.
- States:
  - IDLE: start=1 latches in_vec and act_mode, sets group g=0 and k=0, clears accumulators, goes to MAC.
  - MAC: each cycle, for each lane l, acc[l] += in[k]*W[g*LANES+l][k] (full 2*DATA_W product, sign-extended to ACC_W). k increments. After k = N_INPUTS-1, go to BIAS.
  - BIAS: acc[l] += sign_ext(b[g*LANES+l]) << FRAC_W. Go to ACT.
  - ACT:
    - r = acc[l] >>> FRAC_W (arithmetic shift, truncation toward -inf).
    - If act_mode=1 and r<0, r=0.
    - r is reduced to DATA_W (see Optional Feature) and written to out_vec slot g*LANES+l.
    - If g = N_NEURONS/LANES-1, go to DONE; else g++, k=0, clear accumulators, go to MAC.
  - DONE: out_valid=1 and out_vec held stable. When out_ready=1 (same-cycle handshake), go to IDLE with out_valid=0 the next cycle.
- Latency:
  - Let G = N_NEURONS/LANES. out_valid rises G*(N_INPUTS+2) cycles after the start-acceptance edge.
  - One cycle minimum in DONE. A start asserted while in DONE is ignored, not queued.
- out_vec is updated per group during computation and remains valid after returning to IDLE until the next computation overwrites it.
- Parameter RAM writes:
  - Honoured only in IDLE; ignored while busy.
  - wr_addr beyond N_NEURONS*(N_INPUTS+1)-1 is ignored.
  - A write in the same cycle as start acceptance completes first; the new value is used.
- start and wr_en asserted outside IDLE have no effect.

Optional Feature:
- Macro: DENSE_SAT_EN.
- Defined: the ACT reduction saturates r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: r is truncated to its low DATA_W bits (wrap-around).
- Accumulation is never saturated in either build.

Test Plan:
1. Basic, identity mode. N_INPUTS=4, N_NEURONS=2, LANES=1, DATA_W=16, FRAC_W=8. Load inputs all 0x0100; W0 all 0x0100, b0=0x0080; W1 all 0xFF00, b1=0; act_mode=0; pulse start -> out_valid exactly 12 cycles after acceptance, out_vec = {0xFC00, 0x0480}.
2. ReLU. Same stimulus with act_mode=1 -> neuron1 = 0x0000, neuron0 = 0x0480. Rerun with LANES=2 -> out_valid after 6 cycles, identical values.
3. Overflow. Inputs 0x4000, W0 all 0x0200, b0=0 -> result 0x7FFF with DENSE_SAT_EN defined; 0x0000 without.
4. Backpressure. Hold out_ready=0 for 5 cycles -> out_valid stays 1 and out_vec unchanged. Start pulses during busy and DONE ignored (no second result). out_ready=1 -> IDLE, out_valid=0 next cycle.
5. Reset mid-operation and write protection. Assert reset at MAC cycle 2 -> busy=0, out_valid=0, out_vec=0 next cycle. Restart -> case-1 results reproduced without reloading RAM. A write to W0[0] while busy is ignored, so results are unchanged.
